// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: merges PORTS input streams into one output stream
// through a single output register, holding the grant per packet or per beat.
module axis_rr_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PORTS    = 4,
    parameter int unsigned PKT_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       port_en,
    input  logic [PORTS*WIDTH-1:0] s_rx_tdata,
    input  logic [PORTS-1:0]       s_rx_tvalid,
    input  logic [PORTS-1:0]       s_rx_tlast,
    output logic [PORTS-1:0]       s_rx_tready,
    output logic [WIDTH-1:0]       m_tx_tdata,
    output logic                   m_tx_tvalid,
    output logic                   m_tx_tlast,
    output logic [2:0]             m_tx_tid,
    input  logic                   m_tx_tready
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         last_grant_q, last_grant_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_last_q;
    logic [2:0]         out_tid_q;

    logic               oready;
    logic [PORTS-1:0]   req;
    logic [PORTS-1:0]   req_rot;
    logic               sel_found;
    int unsigned        sel_off;
    logic [2:0]         sel_idx;
    logic               g_valid;
    logic               g_last;
    logic [WIDTH-1:0]   g_data;
    logic               accept;

    assign oready = ~out_valid_q | m_tx_tready;

    // Rotate requests so bit 0 is the port after last_grant; the lowest set bit wins.
    always_comb begin
        req       = s_rx_tvalid & port_en;
        req_rot   = PORTS'({req, req} >> (32'(last_grant_q) + 32'd1));
        sel_found = 1'b0;
        sel_off   = 0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            if (!sel_found && req_rot[k]) begin
                sel_found = 1'b1;
                sel_off   = k;
            end
        end
        sel_idx = 3'((32'(last_grant_q) + 32'd1 + sel_off) % PORTS);
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (grant_q == 3'(i)) begin
                g_valid = s_rx_tvalid[i];
                g_last  = s_rx_tlast[i];
                g_data  = s_rx_tdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_rx_tready  = '0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                for (int unsigned i = 0; i < PORTS; i++) begin
                    if (grant_q == 3'(i)) begin
                        s_rx_tready[i] = oready;
                    end
                end
                accept = g_valid & oready;
                if (accept && ((PKT_MODE == 0) || g_last)) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (m_tx_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 3'(PORTS - 1);
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Payload carries no reset; out_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_data_q <= g_data;
            out_last_q <= g_last;
            out_tid_q  <= grant_q;
        end
    end

    assign m_tx_tdata  = out_data_q;
    assign m_tx_tvalid = out_valid_q;
    assign m_tx_tlast  = out_last_q;
    assign m_tx_tid    = out_tid_q;

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input port and of the output.
REQ-002 Parameter PORTS, default 4: number of input streams; legal range 2..8.
REQ-003 Parameter PKT_MODE, default 1: 1 holds the grant until the tlast beat; 0 re-arbitrates after every beat.
REQ-004 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset; asynchronous, active-high.
REQ-006 Port port_en, input, PORTS bits: per-port arbitration enable.
REQ-007 Port s_rx_tdata, input, PORTS*WIDTH bits: input data; port i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port s_rx_tvalid, input, PORTS bits: per-port valid.
REQ-009 Port s_rx_tlast, input, PORTS bits: per-port end of packet.
REQ-010 Port s_rx_tready, output, PORTS bits: per-port ready.
REQ-011 Port m_tx_tdata, output, WIDTH bits: output data.
REQ-012 Port m_tx_tvalid, output, 1 bit: output valid.
REQ-013 Port m_tx_tlast, output, 1 bit: output end of packet.
REQ-014 Port m_tx_tid, output, 3 bits: index of the source port of the current output beat.
REQ-015 Port m_tx_tready, input, 1 bit: output ready.

Function
REQ-016 The block SHALL have a two-state FSM: IDLE and ACTIVE, plus registers grant[2:0] and last_grant[2:0].
REQ-017 In IDLE, request vector = s_rx_tvalid & port_en; if it is non-zero, the block SHALL select the first set bit, searching circularly from (last_grant+1) mod PORTS.
REQ-018 In IDLE, the block SHALL load the selected port into grant and move to ACTIVE on the next edge; all s_rx_tready bits SHALL be 0 in IDLE.
REQ-019 The output stage SHALL be a single register holding data, last, tid and out_valid; stage ready (oready) = ~out_valid | m_tx_tready.
REQ-020 In ACTIVE, s_rx_tready[grant] SHALL equal oready, and every other s_rx_tready bit SHALL be 0.
REQ-021 On an accepted beat (s_rx_tvalid[grant] & s_rx_tready[grant]), the output register SHALL load that port's data and tlast, with tid = grant, and set out_valid=1.
REQ-022 On m_tx_tvalid & m_tx_tready with no beat loaded in the same cycle, out_valid SHALL clear to 0; a load in the same cycle SHALL take precedence (out_valid stays 1).
REQ-023 Release: on an accepted beat with tlast=1 (PKT_MODE=1), or on any accepted beat (PKT_MODE=0), the FSM SHALL return to IDLE and set last_grant <= grant.
REQ-024 Latency SHALL be 1 cycle from IDLE request detection to the first accept, and 1 cycle from accept to m_tx_tvalid; back-to-back beats within a packet SHALL sustain 1 beat per clock when m_tx_tready=1.
REQ-025 Between packets there SHALL be exactly one IDLE cycle, during which no input is accepted.
REQ-026 Clearing port_en[grant] while ACTIVE SHALL NOT abort the packet; it affects only later arbitration.
REQ-027 Deasserting s_rx_tvalid[grant] mid-packet SHALL keep the FSM in ACTIVE with the grant held; no other port is served meanwhile.
REQ-028 m_tx_tdata, m_tx_tlast and m_tx_tid SHALL stay stable while m_tx_tvalid=1 and m_tx_tready=0.
REQ-029 The block SHALL never accept a beat when the output register is full and m_tx_tready=0.
REQ-030 With PORTS<8, grant values at or above PORTS SHALL be unreachable.

Reset
REQ-031 While rst=1, and immediately on its assertion: FSM=IDLE, out_valid=0, grant=0, last_grant=PORTS-1 (so port 0 has first priority), s_rx_tready=0, m_tx_tvalid=0.
REQ-032 m_tx_tdata, m_tx_tlast and m_tx_tid SHALL have no reset requirement.
REQ-033 Reset asserted mid-packet SHALL drop the buffered beat and the packet in progress; after release, arbitration restarts from port 0.

Verification
REQ-034 All ports valid with 1-beat packets, PKT_MODE=1, m_tx_tready=1 -> tid sequence 0,1,2,3,0..., one output beat every 2 cycles.
REQ-035 Port 2 sends a 5-beat packet while port 0 requests -> 5 consecutive tid=2 beats with tlast on the 5th, then tid=0.
REQ-036 m_tx_tready held 0 for 4 cycles mid-packet -> output frozen, s_rx_tready[grant]=0, no beat lost or duplicated.
REQ-037 port_en=4'b1010 with all ports valid -> only tid 1 and 3 appear, alternating.
REQ-038 rst pulsed during the 3rd beat of a packet -> m_tx_tvalid=0 immediately; the first grant after release goes to the lowest enabled requesting port.
REQ-039 PKT_MODE=0, ports 0 and 1 streaming continuously -> tid alternates 0,1 on every beat, ignoring tlast.
